// File: rtl/uart_tx_streamer_if.sv
// Bus bundle between the byte streamer, the buffer RAM read port and the UART transmit side.
// The streamer connects through the slave modport. The environment connects through the master modport.
interface uart_tx_streamer_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata;
  logic [7:0]        tx_byte;
  logic              transmit;
  logic              tx_busy;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, base_addr, len, ram_rdata, tx_busy,
    output ram_addr, tx_byte, transmit, busy, done, err
  );

  modport master (
    output start, base_addr, len, ram_rdata, tx_busy,
    input  ram_addr, tx_byte, transmit, busy, done, err
  );
endinterface

// File: rtl/uart_tx_streamer.sv
// Streams LEN bytes from buf_ram (starting at BASE_ADDR) into the UART, one transmit handshake per byte.
// Optional macro STREAMER_CHECKSUM_EN appends an XOR-of-data trailer byte to every stream.
module uart_tx_streamer #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned GAP_CYCLES   = 0,
  parameter int unsigned BUSY_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_streamer_if.slave   bus_io
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TMR_W = 8;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);
  localparam bit               HAS_GAP  = (GAP_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE, RD, LOAD, SEND, WBUSY, WDONE, GAP, FIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [TMR_W-1:0]  tmo_q, tmo_d;
  logic [TMR_W-1:0]  gap_q, gap_d;
  logic              transmit_q, transmit_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              byte_done_c;
  logic              next_byte_c;
`ifdef STREAMER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  logic              trl_q, trl_d;
`endif

  // Sequencer: state plus all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ram_addr_q <= '0;
      cnt_q      <= '0;
      tx_byte_q  <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
      transmit_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef STREAMER_CHECKSUM_EN
      csum_q     <= '0;
      trl_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      cnt_q      <= cnt_d;
      tx_byte_q  <= tx_byte_d;
      tmo_q      <= tmo_d;
      gap_q      <= gap_d;
      transmit_q <= transmit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef STREAMER_CHECKSUM_EN
      csum_q     <= csum_d;
      trl_q      <= trl_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    cnt_d       = cnt_q;
    tx_byte_d   = tx_byte_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    transmit_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    byte_done_c = 1'b0;
    next_byte_c = 1'b0;
`ifdef STREAMER_CHECKSUM_EN
    csum_d      = csum_q;
    trl_d       = trl_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus_io.start) begin
          ram_addr_d = bus_io.base_addr;
          cnt_d      = bus_io.len;
          err_d      = 1'b0;
          busy_d     = 1'b1;
`ifdef STREAMER_CHECKSUM_EN
          csum_d     = '0;
          trl_d      = (bus_io.len == '0);
          state_d    = (bus_io.len == '0) ? LOAD : RD;
`else
          state_d    = (bus_io.len == '0) ? FIN : RD;
`endif
        end
      end
      RD: state_d = LOAD;
      LOAD: begin
        // transmit is registered, so raising it here makes it high exactly during SEND
        tx_byte_d  = bus_io.ram_rdata;
`ifdef STREAMER_CHECKSUM_EN
        if (trl_q) tx_byte_d = csum_q;
        else       csum_d    = csum_q ^ bus_io.ram_rdata;
`endif
        transmit_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
`ifdef STREAMER_CHECKSUM_EN
        if (!trl_q) begin
          ram_addr_d = ram_addr_q + ADDR_W'(1);
          cnt_d      = cnt_q - CNT_W'(1);
        end
`else
        ram_addr_d = ram_addr_q + ADDR_W'(1);
        cnt_d      = cnt_q - CNT_W'(1);
`endif
        tmo_d   = '0;
        state_d = WBUSY;
      end
      WBUSY: begin
        if (bus_io.tx_busy) begin
          state_d = WDONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d       = 1'b1;
          byte_done_c = 1'b1;
        end else begin
          tmo_d = tmo_q + TMR_W'(1);
        end
      end
      WDONE: begin
        if (!bus_io.tx_busy) byte_done_c = 1'b1;
      end
      GAP: begin
        if (gap_q == GAP_LAST) next_byte_c = 1'b1;
        else                   gap_d = gap_q + TMR_W'(1);
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (byte_done_c) begin
      if (HAS_GAP) begin
        gap_d   = '0;
        state_d = GAP;
      end else begin
        next_byte_c = 1'b1;
      end
    end

    // Route to the next data byte, the optional trailer, or the end of the stream.
    if (next_byte_c) begin
      if (cnt_q != '0) begin
        state_d = RD;
      end else begin
`ifdef STREAMER_CHECKSUM_EN
        if (!trl_q) begin
          trl_d   = 1'b1;
          state_d = LOAD;
        end else begin
          state_d = FIN;
        end
`else
        state_d = FIN;
`endif
      end
    end
  end

  assign bus_io.ram_addr = ram_addr_q;
  assign bus_io.tx_byte  = tx_byte_q;
  assign bus_io.transmit = transmit_q;
  assign bus_io.busy     = busy_q;
  assign bus_io.done     = done_q;
  assign bus_io.err      = err_q;

endmodule

// File: tb/tb_uart_tx_streamer.sv
// Directed bench for uart_tx_streamer: a table of stream vectors plus hand-timed corner sequences.
// Expectations adapt to the optional STREAMER_CHECKSUM_EN trailer.
module tb_uart_tx_streamer;

  localparam int unsigned AW = 9;
`ifdef STREAMER_CHECKSUM_EN
  localparam int unsigned CK = 1;
`else
  localparam int unsigned CK = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_streamer_if #(.ADDR_W(AW)) sif ();

  uart_tx_streamer #(.ADDR_W(AW), .GAP_CYCLES(0), .BUSY_TIMEOUT(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (sif)
  );

  // Synchronous-read RAM model.
  logic [7:0] mem [512];
  always @(posedge clk) sif.ram_rdata <= mem[sif.ram_addr];

  // UART model: busy for uart_cycles cycles starting the cycle after transmit (0 = never busy).
  int unsigned uart_cycles = 0;
  int unsigned rem = 0;
  always @(posedge clk or posedge rst) begin
    if (rst)                                 rem <= 0;
    else if (sif.transmit && uart_cycles != 0) rem <= uart_cycles;
    else if (rem != 0)                       rem <= rem - 1;
  end
  assign sif.tx_busy = (rem != 0);

  // Monitor.
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0]    got_b[$];
  logic [AW-1:0] got_a[$];
  int unsigned   got_c[$];
  int unsigned   done_cnt = 0;
  int unsigned   err_cyc = 0;
  logic          err_prev = 1'b0;
  always @(negedge clk) begin
    if (sif.transmit) begin
      got_b.push_back(sif.tx_byte);
      got_a.push_back(sif.ram_addr);
      got_c.push_back(cyc);
    end
    if (sif.done) done_cnt++;
    if (sif.err && !err_prev) err_cyc = cyc;
    err_prev = sif.err;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic kick(input int unsigned b, input int unsigned l);
    @(negedge clk);
    got_b.delete(); got_a.delete(); got_c.delete();
    done_cnt = 0; err_cyc = 0;
    sif.base_addr = AW'(b);
    sif.len       = (AW+1)'(l);
    sif.start     = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int unsigned budget);
    int unsigned n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_tx(input string name, input int unsigned k);
    int unsigned n = 0;
    while (got_b.size() < k && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_tx_seen"}, 64'(got_b.size() >= k), 64'd1);
  endtask

  typedef struct {
    int unsigned base;
    int unsigned len;
    int unsigned ubusy;
    int unsigned exp_n;
    int unsigned exp_end;
    logic [7:0]  first_b;
    bit          exp_err;
  } vec_t;

  vec_t vt[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37 + 5);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    vt[0] = '{base: 0,   len: 4,   ubusy: 10, exp_n: 4,   exp_end: 4,   first_b: 8'h11, exp_err: 1'b0};
    vt[1] = '{base: 510, len: 4,   ubusy: 3,  exp_n: 4,   exp_end: 2,   first_b: 8'hBB, exp_err: 1'b0};
    vt[2] = '{base: 100, len: 1,   ubusy: 1,  exp_n: 1,   exp_end: 101, first_b: 8'h79, exp_err: 1'b0};
    vt[3] = '{base: 0,   len: 0,   ubusy: 5,  exp_n: 0,   exp_end: 0,   first_b: 8'h00, exp_err: 1'b0};
    vt[4] = '{base: 7,   len: 512, ubusy: 1,  exp_n: 512, exp_end: 7,   first_b: 8'h08, exp_err: 1'b0};
    vt[5] = '{base: 3,   len: 2,   ubusy: 0,  exp_n: 2,   exp_end: 5,   first_b: 8'h44, exp_err: 1'b1};

    sif.start = 1'b0; sif.base_addr = '0; sif.len = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          {sif.ram_addr, sif.tx_byte, sif.transmit, sif.busy, sif.done, sif.err}, 64'd0);

    // Table-driven streams.
    for (int v = 0; v < 6; v++) begin
      int unsigned badb = 0, bada = 0;
      logic [7:0] x = 8'h00;
      uart_cycles = vt[v].ubusy;
      kick(vt[v].base, vt[v].len);
      wait_done($sformatf("v%0d", v), vt[v].len * 30 + 60);
      check($sformatf("v%0d_ntx", v), 64'(got_b.size()), 64'(vt[v].exp_n + CK));
      check($sformatf("v%0d_done_once", v), 64'(done_cnt), 64'd1);
      check($sformatf("v%0d_end_addr", v), 64'(sif.ram_addr), 64'(vt[v].exp_end));
      check($sformatf("v%0d_err", v), 64'(sif.err), 64'(vt[v].exp_err));
      check($sformatf("v%0d_busy_low", v), 64'(sif.busy), 64'd0);
      if (got_b.size() > 0)
        check($sformatf("v%0d_first_byte", v), 64'(got_b[0]), 64'(vt[v].first_b));
      for (int i = 0; i < int'(vt[v].exp_n) && i < got_b.size(); i++) begin
        logic [AW-1:0] ea;
        ea = AW'(vt[v].base + i);
        x = x ^ mem[ea];
        if (got_b[i] !== mem[ea]) badb++;
        if (got_a[i] !== ea) bada++;
      end
      check($sformatf("v%0d_byte_errs", v), 64'(badb), 64'd0);
      check($sformatf("v%0d_addr_errs", v), 64'(bada), 64'd0);
`ifdef STREAMER_CHECKSUM_EN
      if (got_b.size() == vt[v].exp_n + 1)
        check($sformatf("v%0d_trailer", v), 64'(got_b[vt[v].exp_n]), 64'(x));
`endif
    end

    // Hand-checked addresses for the wrap case.
    uart_cycles = 2;
    kick(510, 4);
    wait_done("wrap", 200);
    if (got_a.size() >= 4)
      check("wrap_addr_seq", {got_a[0], got_a[1], got_a[2], got_a[3]},
            {9'd510, 9'd511, 9'd0, 9'd1});
    check("wrap_end_addr", 64'(sif.ram_addr), 64'd2);

`ifndef STREAMER_CHECKSUM_EN
    // len=0 timing; start held through FIN is ignored, then accepted from IDLE.
    @(negedge clk);
    got_b.delete();
    sif.base_addr = 9'd5; sif.len = '0; sif.start = 1'b1;
    @(negedge clk);
    check("len0_fin_busy_done", {sif.busy, sif.done}, 2'b10);
    @(negedge clk);
    check("len0_done_pulse", {sif.busy, sif.done}, 2'b01);
    @(negedge clk);
    sif.start = 1'b0;
    check("len0_restart_busy", {sif.busy, sif.done}, 2'b10);
    @(negedge clk);
    check("len0_restart_done", {sif.busy, sif.done}, 2'b01);
    check("len0_no_transmit", 64'(got_b.size()), 64'd0);
    check("len0_addr", 64'(sif.ram_addr), 64'd5);
`endif

    // Busy timeout: tx_busy never rises.
    uart_cycles = 0;
    kick(0, 2);
    wait_done("tmo", 200);
    if (got_c.size() >= 2) begin
      check("tmo_byte_spacing", 64'(got_c[1] - got_c[0]), 64'd11);
      check("tmo_err_rise", 64'(err_cyc - got_c[0]), 64'd9);
    end
    check("tmo_err_sticky", 64'(sif.err), 64'd1);
    uart_cycles = 3;
    kick(0, 1);
    check("tmo_err_cleared", 64'(sif.err), 64'd0);
    wait_done("tmo_clr", 100);
    check("tmo_clr_err_low", 64'(sif.err), 64'd0);

    // start pulse during WDONE of byte 1 is ignored.
    uart_cycles = 10;
    kick(0, 3);
    wait_tx("ign", 1);
    repeat (4) @(negedge clk);
    sif.base_addr = 9'd200; sif.len = 10'd7; sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    wait_done("ign", 200);
    check("ign_ntx", 64'(got_b.size()), 64'(3 + CK));
    check("ign_done_once", 64'(done_cnt), 64'd1);
    if (got_b.size() >= 3)
      check("ign_bytes", {got_b[0], got_b[1], got_b[2]}, 24'h112233);
    check("ign_end_addr", 64'(sif.ram_addr), 64'd3);

    // Asynchronous reset in the middle of byte 2 of 5.
    uart_cycles = 10;
    kick(0, 5);
    wait_tx("rst", 2);
    repeat (4) @(negedge clk);
    check("rst_pre_busy", 64'(sif.busy), 64'd1);
    #2 rst = 1'b1;
    #1 check("rst_async_outputs",
             {sif.transmit, sif.busy, sif.done, sif.ram_addr}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_done", 64'(done_cnt), 64'd0);
    uart_cycles = 4;
    kick(2, 1);
    wait_done("rst_after", 100);
    check("rst_after_ntx", 64'(got_b.size()), 64'(1 + CK));
    if (got_b.size() >= 1)
      check("rst_after_byte", 64'(got_b[0]), 64'h33);
    check("rst_after_done", 64'(done_cnt), 64'd1);
    check("rst_after_addr", 64'(sif.ram_addr), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
